// File: rtl/capi_command_arbiter_pkg.sv
// Shared types and helpers for the PSL command arbiter.
// CommandInterfaceOutput / ResponseInterface are the existing PSL bus records.
// Optional feature macro used elsewhere in this slice: ARB_PERF_EN.
package capi_command_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } arb_state;

    typedef struct packed {
        logic        valid;
        logic [7:0]  tag;
        logic        tag_parity;
        logic [12:0] command;
        logic        command_parity;
        logic [2:0]  abt;
        logic [63:0] address;
        logic        address_parity;
        logic [15:0] context_handle;
        logic [11:0] size;
    } CommandInterfaceOutput;

    typedef struct packed {
        logic        valid;
        logic [7:0]  tag;
        logic        tag_parity;
        logic [7:0]  response;
        logic [8:0]  credits;        // two's complement credit return
        logic [1:0]  cache_state;
        logic [12:0] cache_position;
    } ResponseInterface;

    // Requester index held in the upper id_bits of a PSL tag.
    function automatic logic [7:0] tag_id(input logic [7:0] tag, input int id_bits);
        return tag >> (8 - id_bits);
    endfunction

    // Requester-local part of a PSL tag (upper id_bits cleared).
    function automatic logic [7:0] tag_local(input logic [7:0] tag, input int id_bits);
        return tag & (8'hFF >> id_bits);
    endfunction

    // Build a PSL tag from a requester index and its local tag.
    function automatic logic [7:0] tag_join(input logic [7:0] id, input logic [7:0] lt,
                                            input int id_bits);
        return (id << (8 - id_bits)) | (lt & (8'hFF >> id_bits));
    endfunction

endpackage

// File: rtl/capi_command_arbiter_if.sv
// Bundle of requester-side and PSL-side signals around the command arbiter.
// Handshake: a requester raises req_cmd[i].valid and holds all fields stable
// until req_ready[i] pulses for one cycle; the transfer happens in that cycle
// and valid must drop on the next cycle, otherwise it is a new request.
// command_out and resp_out are valid-only (PSL never back-pressures).
interface capi_command_arbiter_if
    import capi_command_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    logic                  enabled;
    logic [7:0]            croom;
    CommandInterfaceOutput req_cmd [NUM_REQ];
    logic [NUM_REQ-1:0]    req_ready;
    CommandInterfaceOutput command_out;
    ResponseInterface      response;
    ResponseInterface      resp_out [NUM_REQ];
    logic                  busy;
    // Observation of internal state
    arb_state              dbg_state;
    logic signed [8:0]     dbg_credits;
    logic [7:0]            dbg_outstanding;

    modport master (
        input  enabled, croom, req_cmd, response,
        output req_ready, command_out, resp_out, busy,
               dbg_state, dbg_credits, dbg_outstanding
    );

    modport slave (
        output enabled, croom, req_cmd, response,
        input  req_ready, command_out, resp_out, busy,
               dbg_state, dbg_credits, dbg_outstanding
    );
endinterface

// File: rtl/capi_command_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping around, returned as a one-hot grant.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant
);
    localparam int PW = $clog2(N);
    localparam int SW = PW + 1;

    logic [SW-1:0] sum;
    logic [PW-1:0] idx;
    logic          found;

    // Scan from ptr upward with wrap, keep the first requester seen.
    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + SW'(k);
            if (sum >= SW'(N)) begin
                sum = sum - SW'(N);
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/capi_command_arbiter.sv
// Shares one PSL command/response interface among NUM_REQ work elements:
// round-robin grant, croom credit accounting, tag rewrite with requester
// index, response routing by tag.
// Optional: define ARB_PERF_EN to add perf_grants / perf_stall counters.
module capi_command_arbiter
    import capi_command_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input logic                    clock,
    input logic                    reset,
    capi_command_arbiter_if.master bus
`ifdef ARB_PERF_EN
    , output logic [31:0]          perf_grants [NUM_REQ]
    , output logic [31:0]          perf_stall
`endif
);
    localparam int ID_BITS = $clog2(NUM_REQ);

    arb_state              state_q, state_d;
    logic                  grant_en;
    logic                  load_croom;
    logic [NUM_REQ-1:0]    req_vec;
    logic [NUM_REQ-1:0]    arb_grant;
    logic                  grant_any;
    logic [ID_BITS-1:0]    winner;
    logic [ID_BITS-1:0]    rr_ptr_q, rr_ptr_d;
    logic signed [8:0]     credits_q, credits_d, resp_credits;
    logic [7:0]            outstanding_q, outstanding_d;
    logic [7:0]            croom_q;
    CommandInterfaceOutput grant_cmd;
    logic                  winner_tag_ok;
    logic [7:0]            resp_id;
    ResponseInterface      resp_route [NUM_REQ];

    // Collect request bits from the requester records.
    always_comb begin
        req_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_vec[i] = bus.req_cmd[i].valid;
        end
    end

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req   (req_vec),
        .ptr   (rr_ptr_q),
        .grant (arb_grant)
    );

    assign bus.req_ready = grant_en ? arb_grant : '0;
    assign grant_any     = |bus.req_ready;

    // One-hot grant to index, and the pointer just past the winner.
    always_comb begin
        winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                winner = ID_BITS'(i);
            end
        end
        rr_ptr_d = (winner == ID_BITS'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; grants only while running and still enabled so that
    // dropping enabled stops new commands immediately.
    always_comb begin
        state_d    = state_q;
        grant_en   = 1'b0;
        load_croom = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.enabled) begin
                    state_d    = RUN;
                    load_croom = 1'b1;
                end
            end
            RUN: begin
                if (!bus.enabled) begin
                    state_d = DRAIN;
                end else begin
                    grant_en = (credits_q > 9'sd0);
                end
            end
            DRAIN: begin
                if (outstanding_q == 8'd0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next credit and outstanding counts; grant and return in one cycle net out.
    always_comb begin
        resp_credits = bus.response.valid ? $signed(bus.response.credits) : 9'sd0;
        if (load_croom) begin
            credits_d = $signed({1'b0, bus.croom});
        end else begin
            credits_d = credits_q - (grant_any ? 9'sd1 : 9'sd0) + resp_credits;
        end
        outstanding_d = outstanding_q + 8'(grant_any) - 8'(bus.response.valid);
    end

    // Credit, outstanding, croom snapshot and round-robin pointer registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            credits_q     <= '0;
            outstanding_q <= '0;
            croom_q       <= '0;
            rr_ptr_q      <= '0;
        end else begin
            credits_q     <= credits_d;
            outstanding_q <= outstanding_d;
            if (load_croom) begin
                croom_q <= bus.croom;
            end
            if (grant_any) begin
                rr_ptr_q <= rr_ptr_d;
            end
        end
    end

    // Winner's command with requester index in the tag and fresh odd parity.
    always_comb begin
        grant_cmd                = bus.req_cmd[winner];
        grant_cmd.valid          = 1'b1;
        grant_cmd.tag            = tag_join(8'(winner), bus.req_cmd[winner].tag, ID_BITS);
        grant_cmd.tag_parity     = ~^grant_cmd.tag;
        grant_cmd.command_parity = ~^grant_cmd.command;
        grant_cmd.address_parity = ~^grant_cmd.address;
        winner_tag_ok            = (tag_id(bus.req_cmd[winner].tag, ID_BITS) == 8'd0);
    end

    // PSL command register: one-cycle pulse the cycle after a grant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.command_out <= '0;
        end else if (grant_any) begin
            bus.command_out <= grant_cmd;
        end else begin
            bus.command_out <= '0;
        end
    end

    // Route the PSL response to the requester named in its upper tag bits.
    always_comb begin
        resp_id = tag_id(bus.response.tag, ID_BITS);
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_route[i] = '0;
            if (!reset && bus.response.valid && resp_id == 8'(i)) begin
                resp_route[i]     = bus.response;
                resp_route[i].tag = tag_local(bus.response.tag, ID_BITS);
            end
        end
    end

    assign bus.resp_out        = resp_route;
    assign bus.busy            = (state_q != IDLE) || (outstanding_q != 8'd0);
    assign bus.dbg_state       = state_q;
    assign bus.dbg_credits     = credits_q;
    assign bus.dbg_outstanding = outstanding_q;

`ifdef ARB_PERF_EN
    // Per-requester grant counters and credit-stall counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                perf_grants[i] <= '0;
            end
            perf_stall <= '0;
        end else if (load_croom) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                perf_grants[i] <= '0;
            end
            perf_stall <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_ready[i]) begin
                    perf_grants[i] <= perf_grants[i] + 32'd1;
                end
            end
            if (state_q == RUN && (|req_vec) && credits_q == 9'sd0) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

    // Credits stay between zero and the croom sampled at job start.
    a_credit_range: assert property (@(posedge clock) disable iff (reset)
        (credits_q >= 9'sd0) && (credits_q <= $signed({1'b0, croom_q})));

    // Requester tags must leave the upper index bits free.
    a_tag_fits: assert property (@(posedge clock) disable iff (reset)
        grant_any |-> winner_tag_ok);

endmodule

// File: tb/tb_capi_command_arbiter.sv
// Directed bench for capi_command_arbiter (4 requesters).
// Honours ARB_PERF_EN when the design is built with it.
module tb_capi_command_arbiter;
    import capi_command_arbiter_pkg::*;

    localparam int NR = 4;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    logic [7:0] exp_q[$];
    logic [7:0] rr_tags [NR];

`ifdef ARB_PERF_EN
    logic [31:0] perf_grants [NR];
    logic [31:0] perf_stall;
`endif

    capi_command_arbiter_if #(.NUM_REQ(NR)) bus ();

    capi_command_arbiter #(.NUM_REQ(NR)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef ARB_PERF_EN
        , .perf_grants (perf_grants)
        , .perf_stall  (perf_stall)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        bus.enabled  = 1'b0;
        bus.croom    = 8'd0;
        bus.response = '0;
        for (int i = 0; i < NR; i++) begin
            bus.req_cmd[i] = '0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic CommandInterfaceOutput make_cmd(input int i, input logic [7:0] t);
        CommandInterfaceOutput c;
        c                = '0;
        c.valid          = 1'b1;
        c.tag            = t;
        c.tag_parity     = 1'b1;
        c.command        = 13'h0A00 | 13'(i);
        c.command_parity = 1'b1;
        c.abt            = 3'(i);
        c.address        = 64'h0000_1000_0000_0000 | (64'(i) << 8);
        c.address_parity = 1'b1;
        c.context_handle = 16'h0042;
        c.size           = 12'd128;
        return c;
    endfunction

    function automatic CommandInterfaceOutput exp_cmd(input int i, input logic [7:0] t,
                                                      input logic [7:0] out_tag);
        CommandInterfaceOutput c;
        c                = make_cmd(i, t);
        c.tag            = out_tag;
        c.tag_parity     = ~^out_tag;
        c.command_parity = ~^c.command;
        c.address_parity = ~^c.address;
        return c;
    endfunction

    function automatic ResponseInterface mk_resp(input logic [7:0] t, input logic [8:0] cr);
        ResponseInterface r;
        r            = '0;
        r.valid      = 1'b1;
        r.tag        = t;
        r.tag_parity = ~^t;
        r.response   = 8'h00;
        r.credits    = cr;
        return r;
    endfunction

    function automatic logic [NR-1:0] resp_valid_vec();
        logic [NR-1:0] v;
        for (int i = 0; i < NR; i++) begin
            v[i] = bus.resp_out[i].valid;
        end
        return v;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int order_err;
        int sb_err;
        int ew;
        int cnt [NR];
        int w;
        logic [7:0] popped;

        total      = 0;
        bad        = 0;
        rr_tags[0] = 8'h10;
        rr_tags[1] = 8'h51;
        rr_tags[2] = 8'h92;
        rr_tags[3] = 8'hD3;

        do_reset();
        mid();
        check("rst_busy", bus.busy, 1'b0);
        check("rst_state", bus.dbg_state, IDLE);
        check("rst_credits", bus.dbg_credits, 9'd0);
        check("rst_outstanding", bus.dbg_outstanding, 8'd0);
        check("rst_cmd", bus.command_out, '0);
        check("rst_ready", bus.req_ready, 4'b0000);
        check("rst_resp_valid", resp_valid_vec(), 4'b0000);

        // ---- croom=2, two requesters, third stalls on credits ----
        cyc();
        bus.croom      = 8'd2;
        bus.enabled    = 1'b1;
        bus.req_cmd[0] = make_cmd(0, 8'h05);
        bus.req_cmd[1] = make_cmd(1, 8'h09);
        mid();
        check("t1_idle_no_grant", bus.req_ready, 4'b0000);
        cyc();
        mid();
        check("t1_state_run", bus.dbg_state, RUN);
        check("t1_grant0", bus.req_ready, 4'b0001);
        cyc();
        bus.req_cmd[0] = '0;
        mid();
        check("t1_cmd0", bus.command_out, exp_cmd(0, 8'h05, 8'h05));
        check("t1_grant1", bus.req_ready, 4'b0010);
        cyc();
        bus.req_cmd[1] = '0;
        bus.req_cmd[2] = make_cmd(2, 8'h03);
        mid();
        check("t1_cmd1_tag", bus.command_out.tag, 8'h49);
        check("t1_cmd1_tpar", bus.command_out.tag_parity, 1'b0);
        check("t1_stall_a", bus.req_ready, 4'b0000);
        cyc();
        mid();
        check("t1_cmd_pulse", bus.command_out.valid, 1'b0);
        check("t1_stall_b", bus.req_ready, 4'b0000);
        check("t1_busy", bus.busy, 1'b1);
        cyc();
        bus.response = mk_resp(8'h05, 9'd1);
        mid();
        check("t1_resp0_valid", resp_valid_vec(), 4'b0001);
        check("t1_resp0_tag", bus.resp_out[0].tag, 8'h05);
        check("t1_credit_not_yet", bus.req_ready, 4'b0000);
        cyc();
        bus.response = '0;
        mid();
        check("t1_grant2", bus.req_ready, 4'b0100);
        cyc();
        bus.req_cmd[2] = '0;
        mid();
        check("t1_cmd2", bus.command_out, exp_cmd(2, 8'h03, 8'h83));
        cyc();
        bus.response = mk_resp(8'h49, 9'd1);
        mid();
        check("t1_resp1_valid", resp_valid_vec(), 4'b0010);
        check("t1_resp1_tag", bus.resp_out[1].tag, 8'h09);
        cyc();
        // ---- response tag 0x83 routes to requester 2 ----
        bus.response = mk_resp(8'h83, 9'd1);
        mid();
        check("t4_route_valid", resp_valid_vec(), 4'b0100);
        check("t4_route_tag", bus.resp_out[2].tag, 8'h03);
`ifdef ARB_PERF_EN
        check("t1_perf_stall", perf_stall, 32'd3);
        check("t1_perf_g2", perf_grants[2], 32'd1);
`endif
        cyc();
        bus.response = '0;
        bus.enabled  = 1'b0;
        cyc();
        cyc();
        mid();
        check("t1_back_idle", bus.dbg_state, IDLE);
        check("t1_idle_busy", bus.busy, 1'b0);
        check("t1_credits_back", bus.dbg_credits, 9'd2);

        // ---- croom=1, grant and credit return in the same cycle ----
        cyc();
        bus.croom   = 8'd1;
        bus.enabled = 1'b1;
        cyc();
        bus.req_cmd[0] = make_cmd(0, 8'h01);
        bus.response   = mk_resp(8'h01, 9'd1);
        mid();
        check("t3_grant0", bus.req_ready, 4'b0001);
        cyc();
        bus.response   = '0;
        bus.req_cmd[0] = '0;
        bus.req_cmd[1] = make_cmd(1, 8'h02);
        mid();
        check("t3_credits_net", bus.dbg_credits, 9'd1);
        check("t3_grant1_next", bus.req_ready, 4'b0010);
        check("t3_cmd0_tag", bus.command_out.tag, 8'h01);
        cyc();
        bus.req_cmd[1] = '0;
        mid();
        check("t3_cmd1_tag", bus.command_out.tag, 8'h42);
        check("t3_credits_zero", bus.dbg_credits, 9'd0);
        check("t3_outstanding", bus.dbg_outstanding, 8'd1);
        cyc();
        bus.response = mk_resp(8'h42, 9'd1);
        bus.enabled  = 1'b0;
        mid();
        check("t3_resp_tag", bus.resp_out[1].tag, 8'h02);
        cyc();
        bus.response = '0;
        cyc();
        mid();
        check("t3_idle", bus.dbg_state, IDLE);
        check("t3_credits_end", bus.dbg_credits, 9'd1);

        // ---- four requesters always valid, croom=64, 400 cycles ----
        do_reset();
        bus.croom   = 8'd64;
        bus.enabled = 1'b1;
        for (int i = 0; i < NR; i++) begin
            bus.req_cmd[i] = make_cmd(i, 8'(8'h10 + i));
            cnt[i]         = 0;
        end
        cyc();
        order_err = 0;
        sb_err    = 0;
        exp_q.delete();
        for (int n = 0; n < 400; n++) begin
            if (bus.command_out.valid) begin
                bus.response = mk_resp(bus.command_out.tag, 9'd1);
            end else begin
                bus.response = '0;
            end
            mid();
            ew = n % NR;
            if (bus.req_ready != 4'(1 << ew)) order_err++;
            for (int i = 0; i < NR; i++) begin
                if (bus.req_ready[i]) cnt[i]++;
            end
            if (bus.command_out.valid) begin
                if (exp_q.size() == 0) begin
                    sb_err++;
                end else begin
                    popped = exp_q.pop_front();
                    if (popped != bus.command_out.tag) sb_err++;
                end
            end
            exp_q.push_back(rr_tags[ew]);
            cyc();
        end
        check("t2_last_cmd_valid", bus.command_out.valid, 1'b1);
        if (exp_q.size() == 0) begin
            sb_err++;
        end else begin
            popped = exp_q.pop_front();
            if (popped != bus.command_out.tag) sb_err++;
        end
        bus.response = mk_resp(bus.command_out.tag, 9'd1);
        for (int i = 0; i < NR; i++) begin
            bus.req_cmd[i] = '0;
        end
        check("t2_rr_order", order_err, 0);
        check("t2_scoreboard", sb_err, 0);
        check("t2_queue_empty", exp_q.size(), 0);
        check("t2_cnt0", cnt[0], 100);
        check("t2_cnt1", cnt[1], 100);
        check("t2_cnt2", cnt[2], 100);
        check("t2_cnt3", cnt[3], 100);
`ifdef ARB_PERF_EN
        for (int i = 0; i < NR; i++) begin
            check("t2_perf_grants", perf_grants[i], 32'd100);
        end
`endif
        cyc();
        bus.response = '0;
        mid();
        check("t2_outstanding_end", bus.dbg_outstanding, 8'd0);
        check("t2_credits_end", bus.dbg_credits, 9'd64);

        // ---- enabled drops with 3 outstanding ----
        cyc();
        bus.req_cmd[0] = make_cmd(0, 8'h21);
        bus.req_cmd[1] = make_cmd(1, 8'h22);
        bus.req_cmd[2] = make_cmd(2, 8'h23);
        mid();
        check("t5_grant0", bus.req_ready, 4'b0001);
        cyc();
        bus.req_cmd[0] = '0;
        mid();
        check("t5_grant1", bus.req_ready, 4'b0010);
        cyc();
        bus.req_cmd[1] = '0;
        mid();
        check("t5_grant2", bus.req_ready, 4'b0100);
        cyc();
        bus.req_cmd[2] = '0;
        bus.enabled    = 1'b0;
        bus.req_cmd[3] = make_cmd(3, 8'h24);
        mid();
        check("t5_no_grant_run", bus.req_ready, 4'b0000);
        check("t5_outstanding3", bus.dbg_outstanding, 8'd3);
        cyc();
        mid();
        check("t5_state_drain", bus.dbg_state, DRAIN);
        check("t5_no_grant_drain", bus.req_ready, 4'b0000);
        cyc();
        bus.response = mk_resp(8'h21, 9'd1);
        mid();
        check("t5_busy_a", bus.busy, 1'b1);
        cyc();
        bus.response = mk_resp(8'h62, 9'd1);
        mid();
        check("t5_busy_b", bus.busy, 1'b1);
        cyc();
        bus.response = mk_resp(8'hA3, 9'd1);
        mid();
        check("t5_busy_c", bus.busy, 1'b1);
        check("t5_no_grant_late", bus.req_ready, 4'b0000);
        cyc();
        bus.response   = '0;
        bus.req_cmd[3] = '0;
        w = 0;
        mid();
        while (bus.busy && w < 8) begin
            cyc();
            mid();
            w++;
        end
        check("t5_drain_done", bus.busy, 1'b0);
        check("t5_idle", bus.dbg_state, IDLE);
        check("t5_outstanding0", bus.dbg_outstanding, 8'd0);

        // ---- reset pulsed while a command is on the bus ----
        cyc();
        bus.croom      = 8'd4;
        bus.enabled    = 1'b1;
        bus.req_cmd[0] = make_cmd(0, 8'h07);
        cyc();
        mid();
        check("t6_grant0", bus.req_ready, 4'b0001);
        cyc();
        check("t6_cmd_before", bus.command_out.valid, 1'b1);
        reset        = 1'b1;
        bus.response = mk_resp(8'h05, 9'd1);
        #1;
        check("t6_cmd_cleared", bus.command_out.valid, 1'b0);
        check("t6_credits_cleared", bus.dbg_credits, 9'd0);
        check("t6_state_idle", bus.dbg_state, IDLE);
        check("t6_outstanding_cleared", bus.dbg_outstanding, 8'd0);
        check("t6_resp_discarded", resp_valid_vec(), 4'b0000);
        check("t6_no_ready", bus.req_ready, 4'b0000);
`ifdef ARB_PERF_EN
        check("t6_perf_g0", perf_grants[0], 32'd0);
        check("t6_perf_stall", perf_stall, 32'd0);
`endif
        cyc();
        clear_inputs();
        reset = 1'b0;
        mid();
        check("t6_busy_after", bus.busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
